// File: rtl/fmap_pingpong_buffer_pkg.sv
// Shared types and frame-size helpers for the feature-map ping-pong buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fmap_pingpong_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Sideband travelling alongside each RAM read through the output pipeline.
    typedef struct packed {
        logic vld;
        logic last;
    } rd_tag_t;

    function automatic int frame_pixels(input int w_in);
        return w_in * w_in;
    endfunction

    function automatic int frame_aw(input int w_in);
        return (w_in * w_in > 1) ? $clog2(w_in * w_in) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// Two-bank simple dual-port RAM, one write port and one registered read port.
// Latency: rd_data valid one clock after rd_en.
// Backpressure: none; caller guarantees a bank is never read and written at once.
module fmap_bank_ram #(
    parameter int DW     = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    // Address is {bank, pixel}, so depth rounds up to a power of two per bank.
    logic [DW-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Captures gapped pooled pixels into two frame banks and replays each as a contiguous raster.
// Latency: first out_ce two clocks after rd_en is sampled in IDLE; N pixels back to back.
// Backpressure: none upstream; pixels arriving with both banks full are dropped and flagged.
module fmap_pingpong_buffer
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int W_IN      = 61
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 in_valid,
    input  logic [dataWidth-1:0] in_data,
    input  logic                 rd_en,
    output logic                 out_ce,
    output logic [dataWidth-1:0] out_data,
    output logic                 out_last,
    output logic [1:0]           bank_full,
    output logic                 overflow
);

    localparam int N  = frame_pixels(W_IN);
    localparam int AW = frame_aw(W_IN);

    // Assert asynchronously, release on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) rst_sync <= 2'b00;
        else               rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic          wr_ok;
    logic          wr_wrap;

    assign wr_ok   = in_valid && !bank_full[wr_bank];
    assign wr_wrap = wr_ok && (wr_cnt == AW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_cnt <= wr_wrap ? '0 : wr_cnt + AW'(1);
                if (wr_wrap) wr_bank <= ~wr_bank;
            end
            if (in_valid && bank_full[wr_bank]) overflow <= 1'b1;
        end
    end

    rd_state_t     state, state_nxt;
    logic          rd_bank;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    rd_tag_t       rd_tag, rd_tag_nxt;
    rd_tag_t       ram_tag;
    logic          rd_done;
    logic [1:0]    bank_full_nxt;
    logic [dataWidth-1:0] ram_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_addr <= '0;
            rd_tag  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            rd_tag  <= rd_tag_nxt;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    // rd_addr/rd_tag are registered, so the RAM sees each issued address one edge later.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        rd_tag_nxt  = '0;
        rd_done     = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank] && rd_en) begin
                    rd_addr_nxt     = '0;
                    rd_tag_nxt.vld  = 1'b1;
                    rd_tag_nxt.last = (N == 1);
                    state_nxt       = (N == 1) ? DRAIN : READ;
                end
            end
            READ: begin
                rd_addr_nxt    = rd_addr + AW'(1);
                rd_tag_nxt.vld = 1'b1;
                if (rd_addr == AW'(N - 2)) begin
                    rd_tag_nxt.last = 1'b1;
                    state_nxt       = DRAIN;
                end
            end
            DRAIN: begin
                rd_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writer only targets empty banks and reader only frees full ones, so the bits never collide.
    always_comb begin
        bank_full_nxt = bank_full;
        if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
        if (wr_wrap) bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_full <= 2'b00;
        else        bank_full <= bank_full_nxt;
    end

    fmap_bank_ram #(
        .DW     (dataWidth),
        .ADDR_W (AW + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr ({wr_bank, wr_cnt}),
        .wr_data (in_data),
        .rd_en   (rd_tag.vld),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_tag  <= '0;
            out_ce   <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
        end else begin
            ram_tag  <= rd_tag;
            out_ce   <= ram_tag.vld;
            out_last <= ram_tag.vld && ram_tag.last;
            if (ram_tag.vld) out_data <= ram_q;
        end
    end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Directed scoreboard bench for fmap_pingpong_buffer at W_IN=4 (16-pixel frames).
module tb_fmap_pingpong_buffer;

    localparam int NPIX = 16;

    logic       clk;
    logic       global_rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rd_en;
    logic       out_ce;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] bank_full;
    logic       overflow;

    fmap_pingpong_buffer #(
        .dataWidth (8),
        .W_IN      (4)
    ) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .rd_en        (rd_en),
        .out_ce       (out_ce),
        .out_data     (out_data),
        .out_last     (out_last),
        .bank_full    (bank_full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] sb[$];       // {last, data}
    logic [7:0] hold_exp = 8'h00;
    bit         in_frame = 0;
    int         zeros = 0;
    int         gap_at_start = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        if (out_ce) begin
            if (!in_frame) begin
                gap_at_start = zeros;
                in_frame = 1;
            end
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix_data", 32'(out_data), 32'(e[7:0]));
                chk("pix_last", 32'(out_last), 32'(e[8]));
                hold_exp = e[7:0];
            end
            if (out_last) begin
                in_frame = 0;
                zeros = 0;
            end
        end else begin
            if (in_frame) chk("contig", 32'(out_ce), 32'd1);
            chk("idle_last", 32'(out_last), 32'd0);
            chk("hold", 32'(out_data), 32'(hold_exp));
            zeros++;
        end
    endtask

    // Drive one cycle of inputs, then observe at the falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rd_en    = r;
        @(negedge clk);
        monitor();
    endtask

    task automatic write_frame(input logic [7:0] base, input logic r, input bit expect_kept);
        for (int i = 0; i < NPIX; i++) begin
            cyc(1'b1, base + 8'(i), r);
            if (expect_kept) sb.push_back({(i == NPIX - 1), base + 8'(i)});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic r, input int budget);
        for (int k = 0; k < budget && sb.size() > 0; k++) cyc(1'b0, 8'h00, r);
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit hit;
        global_rst_n = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_en    = 1'b0;

        // Reset holds everything at zero regardless of input activity.
        for (int i = 0; i < 5; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            chk("rst_outs", {27'd0, out_ce, out_last, bank_full, overflow}, 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
        end
        global_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);

        // Single gapped frame, then a read request.
        for (int i = 0; i < NPIX; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            sb.push_back({(i == NPIX - 1), 8'(i)});
            if (i == NPIX - 2) chk("sf_notfull", 32'(bank_full), 32'd0);
            if (i == NPIX - 1) chk("sf_full", 32'(bank_full), 32'd1);
            cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("sf_idle_ce", 32'(out_ce), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("sf_lat_t0", 32'(out_ce), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("sf_lat_t1", 32'(out_ce), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("sf_lat_t2", 32'(out_ce), 32'd1);
        drain(1'b1, 30);
        cyc(1'b0, 8'h00, 1'b1);
        chk("sf_freed", 32'(bank_full), 32'd0);

        // Ping-pong: B fills while A streams.
        write_frame(8'h10, 1'b1, 1'b1);
        write_frame(8'h20, 1'b1, 1'b1);
        drain(1'b1, 60);
        chk("pp_gap", 32'(gap_at_start), 32'd1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("pp_freed", 32'(bank_full), 32'd0);

        // Overflow: third frame has nowhere to go.
        write_frame(8'h00, 1'b0, 1'b1);
        write_frame(8'h40, 1'b0, 1'b1);
        chk("ov_both_full", 32'(bank_full), 32'd3);
        chk("ov_not_yet", 32'(overflow), 32'd0);
        write_frame(8'h80, 1'b0, 1'b0);
        chk("ov_sticky", 32'(overflow), 32'd1);
        chk("ov_still_full", 32'(bank_full), 32'd3);
        drain(1'b1, 80);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
        chk("ov_freed", 32'(bank_full), 32'd0);
        chk("ov_held", 32'(overflow), 32'd1);

        // One-cycle rd_en pulse still yields a whole frame, and only one.
        write_frame(8'h50, 1'b0, 1'b1);
        write_frame(8'h00, 1'b0, 1'b0);
        chk("md_full", 32'(bank_full), 32'd3);
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 8'h00, 1'b0);
        chk("md_done", 32'(sb.size()), 32'd0);
        chk("md_one_left", 32'(bank_full), 32'd1);

        // Reset while streaming the remaining frame.
        for (int i = 0; i < NPIX; i++) sb.push_back({(i == NPIX - 1), 8'(i)});
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            if (out_ce && out_data == 8'h05) hit = 1;
        end
        chk("mr_reach5", 32'(hit), 32'd1);
        #2 global_rst_n = 1'b0;
        #1;
        chk("mr_async_outs", {28'd0, out_ce, out_last, bank_full}, 32'd0);
        chk("mr_async_data", 32'(out_data), 32'd0);
        chk("mr_async_ovf", 32'(overflow), 32'd0);
        sb.delete();
        in_frame = 0;
        zeros = 0;
        hold_exp = 8'h00;
        cyc(1'b1, 8'hEE, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        global_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        write_frame(8'hA0, 1'b0, 1'b1);
        chk("mr_bank0", 32'(bank_full), 32'd1);
        drain(1'b1, 30);
        cyc(1'b0, 8'h00, 1'b0);
        chk("mr_freed", 32'(bank_full), 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
